ddr_request_arbiter: RTL and testbench
======================================

# ddr_request_arbiter

Shares the single DDR SDRAM command sequencer between two requesters: the video line-fill reader and the drawing-engine writer. It also schedules periodic auto-refresh. It sits between the requesters and the DDR sequencer, issues one command at a time, and tracks that command until the sequencer reports completion. Read/write data paths bypass this block, except the write word, which is forwarded with the command.

## Interface
- ADDR_W, 24, packed DDR address {bank[1:0], row[12:0], col[8:0]}
- REFRESH_INTERVAL, 1000, clk133_p cycles per refresh credit (7.5 µs at 133 MHz, under tREFI 7.8 µs)
- REFRESH_URGENT, 4, refresh debt at which refresh preempts requesters
- STARVE_LIMIT, 4, consecutive read grants with writer waiting before the writer is promoted

Ports:
- clk133_p  in  1  sole clock; everything updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  read request; held until rd_grant
- rd_addr  in  ADDR_W  read address; stable while rd_req high
- rd_grant  out  1  one-cycle pulse: read command accepted by sequencer
- rd_done  out  1  one-cycle pulse: read command completed
- wr_req  in  1  write request; held until wr_grant
- wr_addr  in  ADDR_W  write address; stable while wr_req high
- wr_data  in  32  write word; stable while wr_req high
- wr_grant  out  1  one-cycle pulse: write command accepted
- wr_done  out  1  one-cycle pulse: write command completed
- cmd_valid  out  1  command presented to sequencer
- cmd_op  out  2  01 read, 10 write, 11 refresh, 00 when cmd_valid low
- cmd_addr  out  ADDR_W  command address; 0 for refresh
- cmd_wdata  out  32  write word; 0 unless cmd_op=10
- cmd_ready  in  1  sequencer accepts command this cycle
- cmd_done  in  1  sequencer finished current command (one-cycle pulse)
- refresh_debt  out  4  owed refreshes, 0..8
- refresh_overflow  out  1  sticky: debt hit 8 and another credit arrived

## Operation
- Reset value of every output is 0. On reset: state IDLE, debt 0, refresh counter loaded with REFRESH_INTERVAL-1, starvation count 0, overflow cleared.
- A reset mid-command abandons the command silently; no done pulse is issued. The sequencer is reset on the same rst.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE: evaluate priority, first match wins:
  - refresh if debt ≥ REFRESH_URGENT;
  - write if wr_req and starvation count ≥ STARVE_LIMIT;
  - read if rd_req;
  - write if wr_req;
  - refresh if debt > 0.
  - On a winner, latch op/addr/wdata into the cmd_* registers, set cmd_valid, and go to ISSUE. With no winner, stay in IDLE.
- ISSUE: hold cmd_valid, cmd_op, cmd_addr and cmd_wdata stable until cmd_ready. On cmd_valid&cmd_ready:
  - clear cmd_valid and set cmd_op to 00;
  - pulse the matching grant (combinationally, in the accept cycle);
  - go to WAIT_DONE.
  - Requests arriving during ISSUE never preempt the latched command.
- WAIT_DONE: on cmd_done, pulse the owner's done the next cycle and return to IDLE. cmd_done in IDLE or ISSUE is ignored. Refresh completions produce no done pulse.
- Starvation count:
  - increments on each read grant while wr_req is high, saturating at STARVE_LIMIT;
  - clears on a write grant or when wr_req is low.
- Refresh counter:
  - free-running down-counter;
  - at 0, reload to REFRESH_INTERVAL-1 and add one credit;
  - debt saturates at 8, and a credit arriving at 8 sets refresh_overflow, which stays set until rst;
  - debt decrements on refresh acceptance (cmd_ready);
  - a credit and an acceptance in the same cycle leave debt unchanged.

## Timing
- Request sampled in IDLE at cycle N → cmd_valid high at N+1.
- With cmd_ready high at N+1: grant at N+1, state WAIT_DONE at N+2.
- cmd_done at cycle M → rd_done/wr_done at M+1, state IDLE at M+1. The next cmd_valid is at M+2 at the earliest.
- Minimum spacing between cmd_valid assertions is 3 cycles plus sequencer latency.
- Debt and overflow update in the cycle after the counter reaches 0.

## Test plan
- Idle refresh: reset, no requests, cmd_ready=1.
  - Cycle 1000 after reset release → refresh_debt=1, then cmd_valid with cmd_op=11 and cmd_addr=0; debt returns to 0 on acceptance; no rd_done/wr_done.
- Single read: rd_req with rd_addr=0x000123, cmd_ready=1, cmd_done 6 cycles after grant.
  - cmd_valid/op=01/addr=0x000123 and rd_grant one cycle after the request.
  - rd_done exactly one cycle after cmd_done.
- Backpressure: wr_req with wr_addr=0x1ABCDE, wr_data=0xAAAA5555, cmd_ready=0 for 10 cycles.
  - cmd_op, cmd_addr and cmd_wdata stay constant across all 10 cycles.
  - wr_grant only in the cycle cmd_ready rises.
- Starvation: rd_req and wr_req held continuously, cmd_done always returned → grant order R,R,R,R,W,R,R,R,R,W.
- Urgent refresh: continuous reads with cmd_done delayed so debt reaches 4 → the next IDLE decision issues op=11 ahead of the pending read.
- Overflow and reset: cmd_ready=0 for 9×REFRESH_INTERVAL → debt saturates at 8 and refresh_overflow=1.
  - Then assert rst while in ISSUE → all outputs 0 next cycle and no grant or done pulse.

Source files
------------

// File: rtl/ddr_request_arbiter.sv
// Arbitrates the single DDR command sequencer between the video reader, the drawing-engine
// writer and periodic auto-refresh; one command is tracked from issue to completion.
module ddr_request_arbiter #(
    parameter int unsigned ADDR_W           = 24,
    parameter int unsigned REFRESH_INTERVAL = 1000,
    parameter int unsigned REFRESH_URGENT   = 4,
    parameter int unsigned STARVE_LIMIT     = 4
) (
    input  logic              clk133_p,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_grant,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    output logic              wr_grant,
    output logic              wr_done,
    output logic              cmd_valid,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [31:0]       cmd_wdata,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic [3:0]        refresh_debt,
    output logic              refresh_overflow
);

    localparam int unsigned CntW    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CntW-1:0]    CntReload  = CntW'(REFRESH_INTERVAL - 1);
    localparam logic [StarveW-1:0] StarveMax  = StarveW'(STARVE_LIMIT);
    localparam logic [3:0]         DebtUrgent = 4'(REFRESH_URGENT);
    localparam logic [3:0]         DebtMax    = 4'd8;

    localparam logic [1:0] OpNone    = 2'b00;
    localparam logic [1:0] OpRead    = 2'b01;
    localparam logic [1:0] OpWrite   = 2'b10;
    localparam logic [1:0] OpRefresh = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    state_e              state_q, state_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [1:0]          cmd_op_q, cmd_op_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [31:0]         cmd_wdata_q, cmd_wdata_d;
    logic [1:0]          owner_q, owner_d;
    logic                rd_done_q, rd_done_d;
    logic                wr_done_q, wr_done_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [3:0]          debt_q, debt_d;
    logic                overflow_q, overflow_d;

    logic [1:0] winner_op;
    logic       accept;
    logic       rd_accept, wr_accept, ref_accept;
    logic       credit;

    // Fixed priority; the first matching rule wins.
    always_comb begin
        winner_op = OpNone;
        if (debt_q >= DebtUrgent) begin
            winner_op = OpRefresh;
        end else if (wr_req && (starve_q >= StarveMax)) begin
            winner_op = OpWrite;
        end else if (rd_req) begin
            winner_op = OpRead;
        end else if (wr_req) begin
            winner_op = OpWrite;
        end else if (debt_q != 4'd0) begin
            winner_op = OpRefresh;
        end
    end

    assign accept     = (state_q == StIssue) && cmd_valid_q && cmd_ready;
    assign rd_accept  = accept && (owner_q == OpRead);
    assign wr_accept  = accept && (owner_q == OpWrite);
    assign ref_accept = accept && (owner_q == OpRefresh);

    always_ff @(posedge clk133_p) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OpNone;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            owner_q     <= OpNone;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            starve_q    <= '0;
            cnt_q       <= CntReload;
            debt_q      <= 4'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            owner_q     <= owner_d;
            rd_done_q   <= rd_done_d;
            wr_done_q   <= wr_done_d;
            starve_q    <= starve_d;
            cnt_q       <= cnt_d;
            debt_q      <= debt_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (winner_op != OpNone) state_d = StIssue;
            StIssue:    if (cmd_ready) state_d = StWaitDone;
            StWaitDone: if (cmd_done) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        owner_d     = owner_q;
        rd_done_d   = 1'b0;
        wr_done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (winner_op != OpNone) begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = winner_op;
                    owner_d     = winner_op;
                    cmd_addr_d  = (winner_op == OpRead)  ? rd_addr :
                                  (winner_op == OpWrite) ? wr_addr : '0;
                    cmd_wdata_d = (winner_op == OpWrite) ? wr_data : '0;
                end
            end
            StIssue: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    cmd_op_d    = OpNone;
                    cmd_addr_d  = '0;
                    cmd_wdata_d = '0;
                end
            end
            StWaitDone: begin
                if (cmd_done) begin
                    rd_done_d = (owner_q == OpRead);
                    wr_done_d = (owner_q == OpWrite);
                end
            end
            default: ;
        endcase
    end

    // Writer starvation tracking and the refresh credit/debt bookkeeping.
    always_comb begin
        starve_d = starve_q;
        if (!wr_req || wr_accept) begin
            starve_d = '0;
        end else if (rd_accept && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
        end

        credit     = (cnt_q == '0);
        cnt_d      = credit ? CntReload : cnt_q - 1'b1;
        debt_d     = debt_q;
        overflow_d = overflow_q;
        if (credit && !ref_accept) begin
            if (debt_q == DebtMax) begin
                overflow_d = 1'b1;
            end else begin
                debt_d = debt_q + 4'd1;
            end
        end else if (ref_accept && !credit) begin
            debt_d = debt_q - 4'd1;
        end
    end

    // Grants are suppressed while rst is high so a reset in ISSUE never leaks a pulse.
    assign rd_grant         = rd_accept && !rst;
    assign wr_grant         = wr_accept && !rst;
    assign rd_done          = rd_done_q;
    assign wr_done          = wr_done_q;
    assign cmd_valid        = cmd_valid_q;
    assign cmd_op           = cmd_op_q;
    assign cmd_addr         = cmd_addr_q;
    assign cmd_wdata        = cmd_wdata_q;
    assign refresh_debt     = debt_q;
    assign refresh_overflow = overflow_q;

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// Self-checking bench for ddr_request_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_ddr_request_arbiter;

    localparam int INTV = 1000;
    localparam int URG  = 4;
    localparam int STV  = 4;

    logic        clk = 1'b0;
    logic        rst, rd_req, wr_req, cmd_ready, cmd_done;
    logic [23:0] rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic        rd_grant, rd_done, wr_grant, wr_done, cmd_valid, refresh_overflow;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  refresh_debt;

    always #5 clk = ~clk;

    ddr_request_arbiter #(
        .ADDR_W          (24),
        .REFRESH_INTERVAL(INTV),
        .REFRESH_URGENT  (URG),
        .STARVE_LIMIT    (STV)
    ) dut (
        .clk133_p        (clk),
        .rst             (rst),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_grant        (rd_grant),
        .rd_done         (rd_done),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_grant        (wr_grant),
        .wr_done         (wr_done),
        .cmd_valid       (cmd_valid),
        .cmd_op          (cmd_op),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_ready       (cmd_ready),
        .cmd_done        (cmd_done),
        .refresh_debt    (refresh_debt),
        .refresh_overflow(refresh_overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase 0 = nothing outstanding, 1 = command offered, 2 = command accepted.
    int          m_ph, m_op, m_debt, m_starve, m_cyc;
    bit          m_ovf, m_rdd, m_wrd, m_last_rg, m_last_wg;
    logic [23:0] m_addr;
    logic [31:0] m_data;

    bit    auto_done, spur_en, log_en;
    int    lat;
    string grant_log;

    function automatic logic [67:0] outs();
        return {cmd_valid, cmd_op, cmd_addr, cmd_wdata, rd_grant, wr_grant, rd_done, wr_done,
                refresh_debt, refresh_overflow};
    endfunction

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_op = 0; m_addr = '0; m_data = '0; m_debt = 0; m_starve = 0; m_cyc = 0;
        m_ovf = 0; m_rdd = 0; m_wrd = 0; m_last_rg = 0; m_last_wg = 0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model past the rising edge.
    task automatic cycle();
        logic [67:0] e;
        bit acc, rg, wg, racc, credit;
        int w;
        if (auto_done) begin
            cmd_done = (m_ph == 2 && lat == 0) ||
                       (spur_en && m_ph != 2 && $urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        acc  = (m_ph == 1) && cmd_ready && !rst;
        rg   = acc && (m_op == 1);
        wg   = acc && (m_op == 2);
        racc = acc && (m_op == 3);
        e = {(m_ph == 1), 2'((m_ph == 1) ? m_op : 0), (m_ph == 1) ? m_addr : 24'h0,
             (m_ph == 1 && m_op == 2) ? m_data : 32'h0, rg, wg, m_rdd, m_wrd, 4'(m_debt), m_ovf};
        chk("cycle", outs(), e);
        if (log_en && rd_grant) grant_log = {grant_log, "R"};
        if (log_en && wr_grant) grant_log = {grant_log, "W"};
        @(posedge clk);
        #1;
        m_last_rg = rg;
        m_last_wg = wg;
        if (rst) begin
            model_reset();
        end else begin
            m_cyc++;
            credit = (m_cyc % INTV) == 0;
            m_rdd = 0;
            m_wrd = 0;
            if (m_ph == 0) begin
                if (m_debt >= URG)                 w = 3;
                else if (wr_req && m_starve >= STV) w = 2;
                else if (rd_req)                   w = 1;
                else if (wr_req)                   w = 2;
                else if (m_debt > 0)               w = 3;
                else                               w = 0;
                if (w != 0) begin
                    m_ph   = 1;
                    m_op   = w;
                    m_addr = (w == 1) ? rd_addr : (w == 2) ? wr_addr : 24'h0;
                    m_data = wr_data;
                end
            end else if (m_ph == 1) begin
                if (acc) m_ph = 2;
            end else if (cmd_done) begin
                m_rdd = (m_op == 1);
                m_wrd = (m_op == 2);
                m_ph  = 0;
            end
            if (!wr_req || wg)                 m_starve = 0;
            else if (rg && m_starve < STV)     m_starve++;
            if (credit && !racc) begin
                if (m_debt == 8) m_ovf = 1;
                else             m_debt++;
            end else if (racc && !credit) begin
                m_debt--;
            end
        end
        if (acc && !rst)                 lat = $urandom_range(0, 4);
        else if (m_ph == 2 && lat > 0)   lat--;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst = 1; rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        cmd_ready = 0; cmd_done = 0; auto_done = 0; spur_en = 0; log_en = 0; lat = 0;
        grant_log = "";
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        chk("reset_state", outs(), 68'h0);
        rst = 0;

        // Idle refresh
        cmd_ready = 1;
        repeat (INTV) cycle();
        chk("idle_debt", refresh_debt, 1);
        chk("idle_no_cmd_yet", cmd_valid, 0);
        cycle();
        chk("idle_ref_cmd", {cmd_valid, cmd_op, cmd_addr}, {1'b1, 2'b11, 24'h0});
        cycle();
        chk("idle_debt_cleared", refresh_debt, 0);
        cycle();
        cmd_done = 1; cycle(); cmd_done = 0;
        chk("ref_no_done", {rd_done, wr_done}, 0);

        // Single read
        rd_req = 1; rd_addr = 24'h000123;
        cycle();
        chk("rd_cmd", {cmd_valid, cmd_op, cmd_addr}, {1'b1, 2'b01, 24'h000123});
        chk("rd_grant", rd_grant, 1);
        cycle();
        rd_req = 0;
        repeat (5) cycle();
        chk("rd_done_early", rd_done, 0);
        cmd_done = 1; cycle(); cmd_done = 0;
        chk("rd_done", rd_done, 1);
        cycle();
        chk("rd_done_pulse", rd_done, 0);

        // Backpressure on a write
        cmd_ready = 0; wr_req = 1; wr_addr = 24'h1ABCDE; wr_data = 32'hAAAA5555;
        cycle();
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {cmd_valid, cmd_op, cmd_addr, cmd_wdata, wr_grant},
                {1'b1, 2'b10, 24'h1ABCDE, 32'hAAAA5555, 1'b0});
            cycle();
        end
        cmd_ready = 1;
        #1;
        chk("bp_grant", wr_grant, 1);
        cycle();
        wr_req = 0;
        cmd_done = 1; cycle(); cmd_done = 0;
        chk("wr_done", wr_done, 1);
        cycle();

        // Starvation: both requesters held continuously
        rd_req = 1; wr_req = 1; rd_addr = 24'h0ABC00; wr_addr = 24'h155500;
        wr_data = 32'h12345678; auto_done = 1; log_en = 1; grant_log = "";
        b = 0;
        while (grant_log.len() < 10 && b < 500) begin
            cycle();
            b++;
        end
        n_cmp++;
        assert (grant_log == "RRRRWRRRRW") else begin
            n_err++;
            $error("FAIL starve_order: observed %s expected RRRRWRRRRW", grant_log);
        end
        log_en = 0; rd_req = 0; wr_req = 0;
        b = 0;
        while (m_ph != 0 && b < 50) begin cycle(); b++; end

        // Urgent refresh preempts a pending read
        auto_done = 0; cmd_done = 0; rd_req = 1; rd_addr = 24'h0F0F0F;
        b = 0;
        while (m_ph != 2 && b < 20) begin cycle(); b++; end
        b = 0;
        while (m_debt < URG && b < 5000) begin cycle(); b++; end
        chk("urg_debt", refresh_debt, 4);
        cmd_done = 1; cycle(); cmd_done = 0;
        chk("urg_rd_done", rd_done, 1);
        cycle();
        chk("urg_op", {cmd_valid, cmd_op, cmd_addr}, {1'b1, 2'b11, 24'h0});
        cycle();
        chk("urg_debt_dec", refresh_debt, 3);
        auto_done = 1;
        b = 0;
        while (m_ph != 1 || m_op != 1) begin
            if (b >= 50) break;
            cycle();
            b++;
        end
        chk("urg_then_read", {cmd_valid, cmd_op}, {1'b1, 2'b01});
        rd_req = 0;
        b = 0;
        while ((m_ph != 0 || m_debt != 0) && b < 200) begin cycle(); b++; end

        // Overflow, then reset while a refresh sits in ISSUE
        auto_done = 0; cmd_done = 0; cmd_ready = 0;
        repeat (9 * INTV) cycle();
        chk("ovf_debt", refresh_debt, 8);
        chk("ovf_flag", refresh_overflow, 1);
        chk("ovf_issue", {cmd_valid, cmd_op}, {1'b1, 2'b11});
        cmd_ready = 1; rst = 1;
        cycle();
        chk("rst_outputs", outs(), 68'h0);
        rst = 0; cmd_ready = 0;
        cycle();
        chk("post_rst", outs(), 68'h0);

        // Random traffic
        auto_done = 1; spur_en = 1;
        for (int i = 0; i < 4000; i++) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            if (!rd_req && $urandom_range(0, 2) == 0) begin
                rd_req = 1; rd_addr = 24'($urandom);
            end
            if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req = 1; wr_addr = 24'($urandom); wr_data = $urandom;
            end
            rst = ($urandom_range(0, 999) == 0);
            cycle();
            if (m_last_rg) rd_req = 0;
            if (m_last_wg) wr_req = 0;
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
